// File: rtl/linear_stream_sequencer_pkg.sv
// Shared types and defaults for the linear-layer stream sequencer.
// Element type, FSM encoding and the index-width helper live here.
package linear_pkg;

    localparam int MATRIX_SIZE_DEF = 16;
    localparam int DATA_SIZE_DEF   = 8;

    typedef enum logic [1:0] {LOAD, START, WAIT, DRAIN} seq_state_t;

    typedef logic signed [DATA_SIZE_DEF-1:0] elem_t;

    // Width of a flat element index over an n x n frame; never zero.
    function automatic int idx_width(input int n);
        return (n * n > 1) ? $clog2(n * n) : 1;
    endfunction

endpackage

// File: rtl/linear_stream_sequencer_serializer.sv
// Result buffer for the linear layer: captures the NxN result on done and
// replays it row-major through a valid/ready output stream.
module linear_result_serializer
    import linear_pkg::*;
#(
    parameter int MATRIX_SIZE = MATRIX_SIZE_DEF,
    parameter int DATA_SIZE   = DATA_SIZE_DEF
) (
    input  logic                                                 clk,
    input  logic                                                 reset,
    input  logic                                                 capture,
    input  logic                                                 drain,
    input  logic [MATRIX_SIZE-1:0][MATRIX_SIZE-1:0][DATA_SIZE-1:0] lin_out,
    input  logic                                                 out_ready,
    output logic                                                 out_valid,
    output logic signed [DATA_SIZE-1:0]                          out_data,
    output logic                                                 out_last,
    output logic                                                 drain_done
);

    localparam int                IDX_W    = idx_width(MATRIX_SIZE);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(MATRIX_SIZE * MATRIX_SIZE - 1);

    logic [MATRIX_SIZE-1:0][MATRIX_SIZE-1:0][DATA_SIZE-1:0] result;
    logic [IDX_W-1:0]                                       idx;
    logic signed [DATA_SIZE-1:0]                            sel;
    logic                                                   at_last;

    assign at_last    = (idx == LAST_IDX);
    assign drain_done = drain && out_ready && at_last;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result <= '0;
            idx    <= '0;
        end else begin
            if (capture) begin
                result <= lin_out;
            end
            if (drain_done) begin
                idx <= '0;
            end else if (drain && out_ready) begin
                idx <= idx + 1'b1;
            end
        end
    end

    // Flat index decode keeps non-power-of-two N free of division logic.
    always_comb begin
        sel = '0;
        for (int r = 0; r < MATRIX_SIZE; r++) begin
            for (int c = 0; c < MATRIX_SIZE; c++) begin
                if (idx == IDX_W'(r * MATRIX_SIZE + c)) begin
                    sel = result[r][c];
                end
            end
        end
    end

    // Output is a mux of the captured buffer, so lin_out may move after capture.
    assign out_valid = drain;
    assign out_data  = drain ? sel : '0;
    assign out_last  = drain && at_last;

endmodule

// File: rtl/linear_stream_sequencer.sv
// Streaming front/back end for the linear layer: assembles a row-major input
// frame into mat_a, kicks the layer, and streams the captured result back out.
module linear_stream_sequencer
    import linear_pkg::*;
#(
    parameter int MATRIX_SIZE = MATRIX_SIZE_DEF,
    parameter int DATA_SIZE   = DATA_SIZE_DEF
) (
    input  logic                                                 clk,
    input  logic                                                 reset,
    input  logic                                                 in_valid,
    output logic                                                 in_ready,
    input  logic signed [DATA_SIZE-1:0]                          in_data,
    input  logic                                                 in_last,
    output logic [MATRIX_SIZE-1:0][MATRIX_SIZE-1:0][DATA_SIZE-1:0] mat_a,
    output logic                                                 lin_start,
    input  logic                                                 lin_done,
    input  logic [MATRIX_SIZE-1:0][MATRIX_SIZE-1:0][DATA_SIZE-1:0] lin_out,
    output logic                                                 out_valid,
    input  logic                                                 out_ready,
    output logic signed [DATA_SIZE-1:0]                          out_data,
    output logic                                                 out_last,
    output logic                                                 busy,
    output logic                                                 protocol_err
);

    localparam int                IDX_W    = idx_width(MATRIX_SIZE);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(MATRIX_SIZE * MATRIX_SIZE - 1);

    seq_state_t       state, state_nxt;
    logic [IDX_W-1:0] load_idx;
    logic             accept;
    logic             load_last;
    logic             capture;
    logic             drain;
    logic             drain_done;

    assign accept    = in_valid && (state == LOAD);
    assign load_last = (load_idx == LAST_IDX);
    // Done is only honoured in WAIT, so a stale level during START is harmless.
    assign capture   = (state == WAIT) && lin_done;
    assign drain     = (state == DRAIN);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        lin_start = 1'b0;
        busy      = 1'b1;
        case (state)
            LOAD: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (accept && load_last) begin
                    state_nxt = START;
                end
            end
            START: begin
                lin_start = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (lin_done) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_done) begin
                    state_nxt = LOAD;
                end
            end
            default: begin
                state_nxt = LOAD;
            end
        endcase
    end

    // Load path: sequencing is by count only; in_last just feeds the sticky error.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            load_idx     <= '0;
            mat_a        <= '0;
            protocol_err <= 1'b0;
        end else if (accept) begin
            for (int r = 0; r < MATRIX_SIZE; r++) begin
                for (int c = 0; c < MATRIX_SIZE; c++) begin
                    if (load_idx == IDX_W'(r * MATRIX_SIZE + c)) begin
                        mat_a[r][c] <= in_data;
                    end
                end
            end
            load_idx <= load_last ? '0 : load_idx + 1'b1;
            if (in_last != load_last) begin
                protocol_err <= 1'b1;
            end
        end
    end

    linear_result_serializer #(
        .MATRIX_SIZE (MATRIX_SIZE),
        .DATA_SIZE   (DATA_SIZE)
    ) u_serializer (
        .clk        (clk),
        .reset      (reset),
        .capture    (capture),
        .drain      (drain),
        .lin_out    (lin_out),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_last   (out_last),
        .drain_done (drain_done)
    );

endmodule

// File: tb/tb_linear_stream_sequencer.sv
// Directed/randomized bench for linear_stream_sequencer with a behavioural
// linear-layer model and a row-major reference of the expected output stream.
module tb_linear_stream_sequencer;
    import linear_pkg::*;

    localparam int N  = 16;
    localparam int D  = 8;
    localparam int NN = N * N;

    logic                         clk = 1'b0;
    logic                         reset = 1'b1;
    logic                         in_valid = 1'b0;
    logic                         in_ready;
    logic signed [D-1:0]          in_data = '0;
    logic                         in_last = 1'b0;
    logic [N-1:0][N-1:0][D-1:0]   mat_a;
    logic                         lin_start;
    logic                         lin_done = 1'b0;
    logic [N-1:0][N-1:0][D-1:0]   lin_out = '0;
    logic                         out_valid;
    logic                         out_ready = 1'b0;
    logic signed [D-1:0]          out_data;
    logic                         out_last;
    logic                         busy;
    logic                         protocol_err;

    int checks = 0;
    int errors = 0;

    logic signed [D-1:0] frame [NN];
    logic signed [D-1:0] res   [N][N];
    logic signed [D-1:0] gotd  [NN];
    logic signed [D-1:0] seq3  [NN];

    linear_stream_sequencer #(.MATRIX_SIZE(N), .DATA_SIZE(D)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_last      (in_last),
        .mat_a        (mat_a),
        .lin_start    (lin_start),
        .lin_done     (lin_done),
        .lin_out      (lin_out),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_last     (out_last),
        .busy         (busy),
        .protocol_err (protocol_err)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int mat_a_mismatches(input bool_zero);
        int m = 0;
        for (int k = 0; k < NN; k++) begin
            if ($signed(mat_a[k / N][k % N]) !== (bool_zero ? 8'sd0 : frame[k])) m++;
        end
        return m;
    endfunction

    // Drives one frame; ends at the START cycle sample point.
    task automatic send_frame(input int bad);
        int w;
        for (int k = 0; k < NN; k++) begin
            in_valid = 1'b1;
            in_data  = frame[k];
            in_last  = (k == NN - 1);
            if (k == bad) in_last = !in_last;
            w = 0;
            while (!in_ready && w < 100) begin
                tick();
                w++;
            end
            if (!in_ready) begin
                check("load_timeout", in_ready, 1);
                in_valid = 1'b0;
                return;
            end
            tick();
            if (bad >= 0 && k == bad - 1) check("perr_before_bad_beat", protocol_err, 0);
            if (bad >= 0 && k == bad)     check("perr_after_bad_beat", protocol_err, 1);
            if (k == NN - 2)              check("in_ready_before_last", in_ready, 1);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("in_ready_after_last", in_ready, 0);
        check("lin_start_after_last", lin_start, 1);
        check("busy_in_start", busy, 1);
    endtask

    task automatic set_res(input int mode);
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                res[r][c] = (mode == 0) ? 8'(r - c) : 8'($urandom);
    endtask

    // Behavioural layer: done pulse 5 cycles after start, then scrambles lin_out.
    task automatic run_layer();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                lin_out[r][c] = res[r][c];
        tick();
        check("lin_start_one_cycle", lin_start, 0);
        check("mat_a_frame", mat_a_mismatches(0), 0);
        repeat (4) tick();
        check("no_output_before_done", out_valid, 0);
        lin_done = 1'b1;
        tick();
        lin_done = 1'b0;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                lin_out[r][c] = 8'($urandom);
        check("mat_a_stable_wait", mat_a_mismatches(0), 0);
        check("out_valid_after_done", out_valid, 1);
    endtask

    task automatic drain(input int pct);
        int n = 0;
        int cyc = 0;
        logic signed [D-1:0] od, prev_od;
        logic ov, ol, rdy;
        logic stalled = 1'b0;
        prev_od = '0;
        while (n < NN && cyc < 20000) begin
            ov = out_valid;
            od = out_data;
            ol = out_last;
            if (stalled && ov) check("stall_stable", od, prev_od);
            rdy = ($urandom_range(99) < pct);
            out_ready = rdy;
            tick();
            cyc++;
            if (ov && rdy) begin
                check($sformatf("beat%0d_data", n), od, res[n / N][n % N]);
                check($sformatf("beat%0d_last", n), ol, (n == NN - 1));
                gotd[n] = od;
                n++;
            end
            stalled = ov && !rdy;
            prev_od = od;
        end
        out_ready = 1'b0;
        check("drain_count", n, NN);
        check("in_ready_after_drain", in_ready, 1);
        check("out_valid_after_drain", out_valid, 0);
        check("busy_after_drain", busy, 0);
    endtask

    initial begin
        int m;
        // Test 1: reset state
        #12;
        check("rst_busy", busy, 0);
        check("rst_lin_start", lin_start, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_last", out_last, 0);
        check("rst_protocol_err", protocol_err, 0);
        check("rst_mat_a", mat_a_mismatches(1), 0);
        #5 reset = 1'b0;
        tick();
        check("in_ready_after_reset", in_ready, 1);
        check("busy_after_reset", busy, 0);

        // Test 2 + 3: ramp frame, r-c result, always ready
        for (int k = 0; k < NN; k++) frame[k] = 8'(k - 128);
        send_frame(-1);
        check("mat_a_1_2", $signed(mat_a[1][2]), -110);
        set_res(0);
        run_layer();
        drain(100);
        check("beat17_zero", gotd[17], 0);
        check("beat255_zero", gotd[255], 0);
        check("perr_clean_frame", protocol_err, 0);
        for (int k = 0; k < NN; k++) seq3[k] = gotd[k];

        // Test 4: random frame, same result, random backpressure
        for (int k = 0; k < NN; k++) frame[k] = 8'($urandom);
        send_frame(-1);
        set_res(0);
        run_layer();
        drain(50);
        m = 0;
        for (int k = 0; k < NN; k++) if (gotd[k] !== seq3[k]) m++;
        check("seq_matches_test3", m, 0);

        // Test 5: early in_last on beat 100
        for (int k = 0; k < NN; k++) frame[k] = 8'($urandom);
        send_frame(100);
        set_res(1);
        run_layer();
        drain(70);
        check("perr_persists", protocol_err, 1);

        // Test 6: reset in WAIT, late done pulses ignored
        for (int k = 0; k < NN; k++) frame[k] = 8'($urandom);
        send_frame(-1);
        tick();
        tick();
        #3 reset = 1'b1;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_in_ready", in_ready, 1);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_lin_start", lin_start, 0);
        check("midrst_protocol_err", protocol_err, 0);
        check("midrst_mat_a", mat_a_mismatches(1), 0);
        #2 reset = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            lin_done = 1'b1;
            for (int r = 0; r < N; r++)
                for (int c = 0; c < N; c++)
                    lin_out[r][c] = 8'($urandom);
            tick();
            check("late_done_no_valid", out_valid, 0);
            check("late_done_not_busy", busy, 0);
        end
        lin_done = 1'b0;
        for (int k = 0; k < NN; k++) frame[k] = 8'($urandom);
        send_frame(NN - 1);
        check("perr_missing_last", protocol_err, 1);
        set_res(1);
        run_layer();
        drain(60);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
